gate_vector_sequencer: RTL



---
 rtl/gate_vector_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gate_vector_sequencer.sv
// Self-test sequencer: sweeps a/b over 00,01,10,11 around the logic_gates block and checks its outputs.
// Optional capture of per-vector failures and the first failing vector: GATE_SEQ_CAPTURE_EN.
module gate_vector_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a_out,
  output logic             b_out,
  input  logic [6:0]       gate_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [6:0]       mismatch_mask
`ifdef GATE_SEQ_CAPTURE_EN
  ,
  output logic [3:0]       fail_vec,
  output logic [8:0]       first_fail
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [7:0]       SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ErrMax     = '1;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [6:0]       mask_q, mask_d;
  logic             pass_q, pass_d;
  logic [6:0]       expected, diff;
  logic [1:0]       idx_nxt;

  assign expected = {~(a_q ^ b_q), a_q ^ b_q, ~b_q, ~(a_q | b_q), ~(a_q & b_q), a_q | b_q,
                     a_q & b_q};
  assign diff     = gate_in ^ expected;
  assign idx_nxt  = idx_q + 2'd1;

`ifdef GATE_SEQ_CAPTURE_EN
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [8:0] first_fail_q, first_fail_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
`ifdef GATE_SEQ_CAPTURE_EN
    fail_vec_d   = fail_vec_q;
    first_fail_d = first_fail_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          cnt_d   = 8'd0;
          state_d = StSettle;
`ifdef GATE_SEQ_CAPTURE_EN
          fail_vec_d   = '0;
          first_fail_d = '0;
`endif
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SettleLast) state_d = StSample;
      end
      StSample: begin
        if (diff != 7'd0) begin
          if (err_q != ErrMax) err_d = err_q + 1'b1;
          mask_d = mask_q | diff;
`ifdef GATE_SEQ_CAPTURE_EN
          fail_vec_d[idx_q] = 1'b1;
          if (!first_fail_q[8]) first_fail_d = {1'b1, idx_q, diff[5:0]};
`endif
        end
        if (idx_q != 2'd3) begin
          idx_d   = idx_nxt;
          a_d     = idx_nxt[1];
          b_d     = idx_nxt[0];
          cnt_d   = 8'd0;
          state_d = StSettle;
        end else begin
          state_d = StDone;
          pass_d  = (err_d == '0);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort discards any sample taken this cycle; accumulated results stay visible.
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      err_d   = err_q;
      mask_d  = mask_q;
      pass_d  = 1'b0;
      a_d     = 1'b0;
      b_d     = 1'b0;
`ifdef GATE_SEQ_CAPTURE_EN
      fail_vec_d   = fail_vec_q;
      first_fail_d = first_fail_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

`ifdef GATE_SEQ_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec_q   <= '0;
      first_fail_q <= '0;
    end else begin
      fail_vec_q   <= fail_vec_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign fail_vec   = fail_vec_q;
  assign first_fail = first_fail_q;
`endif

  assign a_out         = a_q;
  assign b_out         = b_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign mismatch_mask = mask_q;

endmodule
